dmem_lsu: RTL and testbench

Load/store unit that sits between the CPU execute stage and the byte-addressed, big-endian data memory `DMEM`, and drives that memory. It accepts one load or store request at a time over a valid/ready handshake and checks alignment and address range. It then drives the memory's registered read/write port with the correct byte-lane select. Load data is extracted and sign- or zero-extended, and a single response (data or error code) is returned over a valid/ready handshake.

---
 rtl/dmem_lsu_pkg.sv | 56 +++++
 rtl/dmem_lsu_if.sv | 35 +++
 rtl/dmem_lsu_load_align.sv | 35 +++
 rtl/dmem_lsu.sv | 119 +++++++++++
 tb/tb_dmem_lsu.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the DMEM load/store unit: access sizes, response codes,
// FSM states and the request legality check.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BAD  = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_BADSIZE  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            SZ_WORD: size_bytes = 3'd4;
            default: size_bytes = 3'd1;
        endcase
    endfunction

    // Bad size outranks misalignment, which outranks range.
    function automatic err_e check_req(input logic [1:0]  size,
                                       input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [32:0] limit);
        logic [31:0] offset;
        logic [32:0] last;
        offset = addr - base;
        last   = {1'b0, offset} + {30'b0, size_bytes(size)} - 33'd1;
        if (size == SZ_BAD) begin
            check_req = ERR_BADSIZE;
        end else if ((size == SZ_HALF && addr[0] != 1'b0) ||
                     (size == SZ_WORD && addr[1:0] != 2'b00)) begin
            check_req = ERR_MISALIGN;
        end else if (last >= limit) begin
            check_req = ERR_RANGE;
        end else begin
            check_req = ERR_OK;
        end
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// CPU request/response handshake plus the DMEM port, bundled for the LSU.
// The slave view is the LSU; the master view is the CPU and memory around it.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        mem_rena;
    logic        mem_wena;
    logic [1:0]  mem_select;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_rena, mem_wena, mem_select, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_rena, mem_wena, mem_select, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_lsu_load_align.sv
// Extracts a big-endian byte/half/word from the top of a 32-bit read word and
// sign- or zero-extends it to 32 bits.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    // Lane extraction and extension.
    always_comb begin
        data_o = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: begin
                if (unsigned_i) begin
                    data_o = {24'h00_0000, rdata_i[31:24]};
                end else begin
                    data_o = {{24{rdata_i[31]}}, rdata_i[31:24]};
                end
            end
            SZ_HALF: begin
                if (unsigned_i) begin
                    data_o = {16'h0000, rdata_i[31:16]};
                end else begin
                    data_o = {{16{rdata_i[31]}}, rdata_i[31:16]};
                end
            end
            SZ_WORD: data_o = rdata_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit in front of the registered, big-endian DMEM:
// checks each request, performs one memory access and returns one response.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
    parameter int unsigned DMEM_BYTES = 1024
) (
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.slave bus
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    err_e        err_q, err_d;
    err_e        check_s;
    logic [31:0] align_data_s;

    assign check_s = check_req(bus.req_size, bus.req_addr, DMEM_BASE, 33'(DMEM_BYTES));

    lsu_load_align u_align (
        .rdata_i    (bus.mem_rdata),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (align_data_s)
    );

    // Next state and holding-register updates.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'h0000_0000;
                    err_d   = check_s;
                    if (check_s != ERR_OK) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rdata_d = align_data_s;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Enables decode straight from the state flop so reset kills them at once.
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_rena   = (state_q == ST_ISSUE) && !we_q;
    assign bus.mem_wena   = (state_q == ST_ISSUE) && we_q;
    assign bus.mem_select = size_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = we_q ? wdata_q : 32'h0000_0000;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu with a behavioural DMEM and a
// byte-array reference model of the memory contents and LSU responses.
module tb_dmem_lsu;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dmem_lsu_if bus_if ();

    dmem_lsu #(.DMEM_BASE(BASE), .DMEM_BYTES(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [7:0] dmem    [0:1023];
    logic [7:0] ref_mem [0:1023];

    // Behavioural DMEM: registered big-endian port, wrapping inside the window.
    always @(posedge clk) begin
        logic [31:0] off;
        logic [9:0]  idx;
        off = bus_if.mem_addr - BASE;
        idx = off[9:0];
        if (bus_if.mem_wena) begin
            case (bus_if.mem_select)
                2'b01: dmem[idx] = bus_if.mem_wdata[7:0];
                2'b10: begin
                    dmem[idx]         = bus_if.mem_wdata[15:8];
                    dmem[idx + 10'd1] = bus_if.mem_wdata[7:0];
                end
                2'b11: begin
                    dmem[idx]         = bus_if.mem_wdata[31:24];
                    dmem[idx + 10'd1] = bus_if.mem_wdata[23:16];
                    dmem[idx + 10'd2] = bus_if.mem_wdata[15:8];
                    dmem[idx + 10'd3] = bus_if.mem_wdata[7:0];
                end
                default: ;
            endcase
        end
        if (bus_if.mem_rena) begin
            bus_if.mem_rdata <= {dmem[idx], dmem[idx + 10'd1], dmem[idx + 10'd2], dmem[idx + 10'd3]};
        end
    end

    int         wena_tot = 0;
    int         rena_tot = 0;
    int         both_tot = 0;
    logic [1:0] last_sel = 2'b00;

    // Memory-port activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_if.mem_wena) wena_tot++;
        if (bus_if.mem_rena) rena_tot++;
        if (bus_if.mem_wena && bus_if.mem_rena) both_tot++;
        if (bus_if.mem_wena || bus_if.mem_rena) last_sel = bus_if.mem_select;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int ref_bytes(input logic [1:0] sz);
        return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
    endfunction

    function automatic logic [1:0] ref_err(input logic [1:0] sz, input logic [31:0] addr);
        longint off;
        int     n;
        if (sz == 2'd0) return 2'd3;
        n = ref_bytes(sz);
        if ((addr % n) != 0) return 2'd1;
        off = longint'(addr) - longint'(BASE);
        if (off < 0 || off + n > 1024) return 2'd2;
        return 2'd0;
    endfunction

    // One complete transaction, checked against the reference model.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input string tag);
        logic [1:0]  e;
        logic [31:0] exp_d;
        longint      v;
        int          n, off, lat, exp_lat, w0, r0, b0;
        e     = ref_err(sz, addr);
        exp_d = 32'h0;
        if (e == 2'd0) begin
            n   = ref_bytes(sz);
            off = int'(addr - BASE);
            if (we) begin
                for (int k = 0; k < n; k++) ref_mem[off + k] = 8'(wdata >> (8 * (n - 1 - k)));
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v * 256 + longint'(ref_mem[off + k]);
                if (!uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
                exp_d = v[31:0];
            end
        end
        exp_lat = (e != 2'd0) ? 1 : (we ? 2 : 3);
        chk({tag, " ready_idle"}, {31'b0, bus_if.req_ready}, 32'd1);
        w0 = wena_tot; r0 = rena_tot; b0 = both_tot;
        bus_if.req_valid    = 1'b1;
        bus_if.req_we       = we;
        bus_if.req_size     = sz;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wdata;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        chk({tag, " ready_busy"}, {31'b0, bus_if.req_ready}, 32'd0);
        lat = 1;
        while (!bus_if.resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " err"}, {30'b0, bus_if.resp_err}, {30'b0, e});
        chk({tag, " rdata"}, bus_if.resp_rdata, exp_d);
        chk({tag, " wena_pulses"}, wena_tot - w0, (e == 2'd0 && we) ? 1 : 0);
        chk({tag, " rena_pulses"}, rena_tot - r0, (e == 2'd0 && !we) ? 1 : 0);
        chk({tag, " rena_wena_overlap"}, both_tot - b0, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, {31'b0, bus_if.resp_valid}, 32'd1);
            chk({tag, " hold_rdata"}, bus_if.resp_rdata, exp_d);
            chk({tag, " hold_err"}, {30'b0, bus_if.resp_err}, {30'b0, e});
            chk({tag, " hold_ready"}, {31'b0, bus_if.req_ready}, 32'd0);
        end
        bus_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.resp_ready = 1'b0;
        chk({tag, " handoff_valid"}, {31'b0, bus_if.resp_valid}, 32'd0);
        chk({tag, " handoff_ready"}, {31'b0, bus_if.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 8'((i * 37 + 11) & 255);
            ref_mem[i] = 8'((i * 37 + 11) & 255);
        end
        rst = 1'b1;
        bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_size = 2'b00;
        bus_if.req_unsigned = 1'b0; bus_if.req_addr = 32'h0; bus_if.req_wdata = 32'h0;
        bus_if.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset req_ready", {31'b0, bus_if.req_ready}, 32'd1);
        chk("reset resp_valid", {31'b0, bus_if.resp_valid}, 32'd0);
        chk("reset resp_rdata", bus_if.resp_rdata, 32'd0);
        chk("reset resp_err", {30'b0, bus_if.resp_err}, 32'd0);
        chk("reset mem_en", {30'b0, bus_if.mem_rena, bus_if.mem_wena}, 32'd0);
        chk("reset mem_addr", bus_if.mem_addr, 32'd0);
        chk("reset mem_sel", {30'b0, bus_if.mem_select}, 32'd0);
        chk("reset mem_wdata", bus_if.mem_wdata, 32'd0);

        do_req(1'b1, 2'd3, 1'b0, BASE, 32'hDEAD_BEEF, 0, "sw");
        chk("sw select", {30'b0, last_sel}, 32'd3);
        do_req(1'b0, 2'd3, 1'b0, BASE, 32'h0, 0, "lw");
        chk("lw literal", bus_if.resp_rdata, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd1, 1'b0, BASE, 32'h0, 0, "lb");
        do_req(1'b0, 2'd1, 1'b1, BASE, 32'h0, 0, "lbu");
        do_req(1'b0, 2'd2, 1'b0, BASE + 32'd2, 32'h0, 0, "lh");
        do_req(1'b0, 2'd2, 1'b1, BASE + 32'd2, 32'h0, 0, "lhu");
        do_req(1'b1, 2'd1, 1'b0, BASE + 32'd1, 32'h0000_0055, 0, "sb");
        chk("sb select", {30'b0, last_sel}, 32'd1);
        do_req(1'b0, 2'd3, 1'b0, BASE, 32'h0, 0, "lw_after_sb");
        do_req(1'b0, 2'd3, 1'b0, BASE + 32'd2, 32'h0, 0, "lw_misalign");
        do_req(1'b0, 2'd2, 1'b0, 32'h1001_03FF, 32'h0, 0, "lh_misalign");
        do_req(1'b0, 2'd3, 1'b0, 32'h1001_0400, 32'h0, 0, "lw_range");
        do_req(1'b0, 2'd1, 1'b0, 32'h0FFF_FFFF, 32'h0, 0, "lb_below");
        do_req(1'b1, 2'd0, 1'b0, BASE + 32'd3, 32'h1, 0, "bad_size");
        do_req(1'b0, 2'd1, 1'b1, 32'h1001_03FF, 32'h0, 0, "lbu_last");
        do_req(1'b0, 2'd3, 1'b0, BASE, 32'h0, 5, "lw_backpressure");

        // Abort a store with an asynchronous reset pulse during its ISSUE cycle.
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_size = 2'd3;
        bus_if.req_unsigned = 1'b0; bus_if.req_addr = BASE + 32'd8; bus_if.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        chk("abort issue_wena", {31'b0, bus_if.mem_wena}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort wena_drop", {31'b0, bus_if.mem_wena}, 32'd0);
        chk("abort mem_addr", bus_if.mem_addr, 32'd0);
        chk("abort resp_valid", {31'b0, bus_if.resp_valid}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("abort req_ready", {31'b0, bus_if.req_ready}, 32'd1);
        do_req(1'b0, 2'd3, 1'b0, BASE + 32'd8, 32'h0, 0, "lw_after_abort");

        for (int t = 0; t < 80; t++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0, 1, 2: a = BASE + 32'($urandom_range(0, 1023));
                3:       a = BASE + 32'd1016 + 32'($urandom_range(0, 15));
                default: a = BASE - 32'd4 + 32'($urandom_range(0, 7));
            endcase
            if ($urandom_range(0, 2) != 0) a = a & ~(32'(ref_bytes(sz)) - 32'd1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(0, 2), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
